gpu_draw_ctrl: RTL and testbench

// - Sequences the display unit for CHIP-8 CLS (00E0) and DRW Vx,Vy,n (DXYN).
// - Accepts one command at a time from the CPU.
// - For a draw, fetches n sprite bytes from memory starting at I and packs them into the 120-bit sprite bus.
// - Drives the display's two-cycle draw phase, then returns the collision flag (VF) to the CPU with a done pulse.
// - Sits between the CPU execute stage, the main memory read port and the display unit.

---
 rtl/gpu_draw_ctrl_if.sv | 41 ++++
 rtl/gpu_draw_ctrl.sv | 149 ++++++++++++++
 tb/tb_gpu_draw_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_draw_ctrl_if.sv
// Handshake bundle between the CPU/memory/display side and the draw controller.
interface gpu_draw_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int MAX_H  = 15
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_clear;
    logic [7:0]           cmd_x;
    logic [7:0]           cmd_y;
    logic [3:0]           cmd_n;
    logic [ADDR_W-1:0]    cmd_i;
    logic                 done;
    logic [7:0]           done_vf;
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_ack;
    logic [7:0]           mem_rdata;
    logic                 gpu_clear;
    logic                 gpu_draw;
    logic [7:0]           gpu_row;
    logic [7:0]           gpu_col;
    logic [3:0]           gpu_height;
    logic [8*MAX_H-1:0]   gpu_sprite_data;
    logic [7:0]           gpu_vf;
    logic                 vblank;

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_i,
        input  mem_ack, mem_rdata, gpu_vf, vblank,
        output cmd_ready, done, done_vf, mem_req, mem_addr,
        output gpu_clear, gpu_draw, gpu_row, gpu_col, gpu_height, gpu_sprite_data
    );

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_n, cmd_i,
        output mem_ack, mem_rdata, gpu_vf, vblank,
        input  cmd_ready, done, done_vf, mem_req, mem_addr,
        input  gpu_clear, gpu_draw, gpu_row, gpu_col, gpu_height, gpu_sprite_data
    );
endinterface

// File: rtl/gpu_draw_ctrl.sv
// CHIP-8 CLS/DRW sequencer: fetches sprite bytes, runs the two-cycle display phase, returns VF.
// Macro GPU_VBLANK_WAIT_EN: DRW with n>0 waits for a vblank pulse before fetching.
module gpu_draw_ctrl #(
    parameter int ADDR_W = 12,
    parameter int MAX_H  = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    gpu_draw_ctrl_if.slave bus
);
    localparam int SPR_W = 8 * MAX_H;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAITVB, S_FETCH, S_DRAW0, S_DRAW1, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_clear;
    logic [5:0]          r_col;
    logic [4:0]          r_row;
    logic [3:0]          r_n;
    logic [3:0]          r_k;
    logic [ADDR_W-1:0]   r_i;
    logic [SPR_W-1:0]    r_sprite;

    logic                w_accept;
    logic                w_is_draw;
    logic                w_last;
    logic                w_busy;
    logic                w_cmd_ready;
    logic                w_done;
    logic                w_mem_req;
    logic                w_gpu_clear;
    logic                w_gpu_draw;
    logic [7:0]          w_done_vf;
    logic                w_unused;

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_is_draw = !r_clear && (r_n != 4'd0);
    assign w_last    = ((r_k + 4'd1) == r_n);
    assign w_busy    = (r_state != S_IDLE);
    assign w_unused  = ^{bus.vblank, bus.gpu_vf[7:1], bus.cmd_x[7:6], bus.cmd_y[7:5]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_done      = 1'b0;
        w_done_vf   = 8'h00;
        w_mem_req   = 1'b0;
        w_gpu_clear = 1'b0;
        w_gpu_draw  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_clear) begin
                        w_next = S_CLEAR;
                    end else if (bus.cmd_n == 4'd0) begin
                        w_next = S_DONE;
                    end else begin
`ifdef GPU_VBLANK_WAIT_EN
                        w_next = S_WAITVB;
`else
                        w_next = S_FETCH;
`endif
                    end
                end
            end
            S_CLEAR: begin
                w_gpu_clear = 1'b1;
                w_next      = S_DONE;
            end
            S_WAITVB: begin
`ifdef GPU_VBLANK_WAIT_EN
                if (bus.vblank) begin
                    w_next = S_FETCH;
                end
`else
                w_next = S_FETCH;
`endif
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack && w_last) begin
                    w_next = S_DRAW0;
                end
            end
            S_DRAW0: begin
                w_gpu_draw = 1'b1;
                w_next     = S_DRAW1;
            end
            S_DRAW1: begin
                w_gpu_draw = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                w_done    = 1'b1;
                w_done_vf = w_is_draw ? {7'b0, bus.gpu_vf[0]} : 8'h00;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Row 0 lands in the top byte; each slot is written once after the accept-time clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clear  <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_sprite <= '0;
        end else if (w_accept) begin
            r_clear  <= bus.cmd_clear;
            r_col    <= bus.cmd_x[5:0];
            r_row    <= bus.cmd_y[4:0];
            r_n      <= bus.cmd_n;
            r_i      <= bus.cmd_i;
            r_k      <= '0;
            r_sprite <= '0;
        end else if (r_state == S_FETCH && bus.mem_ack) begin
            r_sprite <= r_sprite | (SPR_W'(bus.mem_rdata) << (8 * (MAX_H - 1 - int'(r_k))));
            r_k      <= r_k + 4'd1;
        end
    end

    assign bus.cmd_ready       = w_cmd_ready;
    assign bus.done            = w_done;
    assign bus.done_vf         = w_done_vf;
    assign bus.mem_req         = w_mem_req;
    assign bus.mem_addr        = r_i + ADDR_W'(r_k);
    assign bus.gpu_clear       = w_gpu_clear;
    assign bus.gpu_draw        = w_gpu_draw;
    assign bus.gpu_row         = w_busy ? {3'b000, r_row} : 8'h00;
    assign bus.gpu_col         = w_busy ? {2'b00, r_col} : 8'h00;
    assign bus.gpu_height      = w_busy ? r_n : 4'd0;
    assign bus.gpu_sprite_data = r_sprite;
endmodule

// File: tb/tb_gpu_draw_ctrl.sv
// Randomised scoreboard bench for gpu_draw_ctrl: driver pushes model expectations, monitors pop and compare.
`timescale 1ns/1ps
module tb_gpu_draw_ctrl;
    localparam int ADDR_W = 12;
    localparam int MAX_H  = 15;
    localparam int SW     = 8 * MAX_H;
    localparam int MEM_SZ = 1 << ADDR_W;

    typedef struct {
        logic [7:0]    vf;
        int            lat;
        int            draws;
        int            clears;
        logic [SW-1:0] sprite;
        logic [7:0]    row;
        logic [7:0]    col;
        logic [3:0]    height;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gpu_draw_ctrl_if #(.ADDR_W(ADDR_W), .MAX_H(MAX_H)) bus ();
    gpu_draw_ctrl #(.ADDR_W(ADDR_W), .MAX_H(MAX_H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int               n_chk    = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               acc_cyc  = 0;
    int               draw_cnt = 0;
    int               clr_cnt  = 0;
    int               ack_cnt  = 0;
    logic [7:0]       mem [MEM_SZ];
    exp_t             exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int               wait_q [$];
    exp_t             mon_e;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Display side and completion monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            draw_cnt = 0;
            clr_cnt  = 0;
        end else begin
            if (bus.gpu_draw) begin
                draw_cnt++;
                if (exp_q.size() == 0) check("draw_unexpected", 1, 0);
                else begin
                    check("sprite", bus.gpu_sprite_data, exp_q[0].sprite);
                    check("gpu_row", bus.gpu_row, exp_q[0].row);
                    check("gpu_col", bus.gpu_col, exp_q[0].col);
                    check("gpu_height", bus.gpu_height, exp_q[0].height);
                end
            end
            if (bus.gpu_clear) clr_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("done_vf", bus.done_vf, mon_e.vf);
                    check("latency", cyc - acc_cyc, mon_e.lat);
                    check("draw_cycles", draw_cnt, mon_e.draws);
                    check("clear_cycles", clr_cnt, mon_e.clears);
                end
                draw_cnt = 0;
                clr_cnt  = 0;
            end else begin
                check("done_vf_idle", bus.done_vf, 0);
            end
        end
    end

    // Memory responder with per-byte wait states chosen by the driver.
    int               rem  = 0;
    bit               busy = 1'b0;
    logic [ADDR_W-1:0] held;
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
        end else if (bus.mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                held = bus.mem_addr;
                if (addr_q.size() == 0) begin
                    check("mem_req_unexpected", 1, 0);
                    rem = 0;
                end else begin
                    check("mem_addr", bus.mem_addr, addr_q.pop_front());
                    rem = wait_q.pop_front();
                end
            end else begin
                check("mem_addr_stable", bus.mem_addr, held);
            end
            if (rem == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[held];
                busy          = 1'b0;
                ack_cnt++;
            end else begin
                rem--;
            end
        end else if ($urandom_range(7) == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 8'($urandom);
        end
    end

`ifndef GPU_VBLANK_WAIT_EN
    always @(negedge clk) bus.vblank = 1'($urandom_range(1));
`endif

    task automatic start_cmd(input bit clr, input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                             input logic [ADDR_W-1:0] i, input logic [7:0] vf, input int fixed_wait,
                             input int vb_delay);
        exp_t              e;
        int                w;
        int                guard;
        logic [ADDR_W-1:0] a;
        logic [SW-1:0]     spr;
        logic [ADDR_W-1:0] al [$];
        int                wl [$];
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = clr;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_n     = n;
        bus.cmd_i     = i;
        bus.gpu_vf    = vf;
        spr = '0;
        if (clr) e.lat = 2;
        else if (n == 0) e.lat = 1;
        else begin
            e.lat = 3;
            for (int k = 0; k < MAX_H; k++) begin
                a   = i + ADDR_W'(k);
                spr = (spr << 8) | SW'((k < int'(n)) ? mem[a] : 8'h00);
                if (k < int'(n)) begin
                    w = (fixed_wait < 0) ? int'($urandom_range(3)) : fixed_wait;
                    al.push_back(a);
                    wl.push_back(w);
                    e.lat += 1 + w;
                end
            end
`ifdef GPU_VBLANK_WAIT_EN
            e.lat += vb_delay + 1;
`endif
        end
        e.vf     = (clr || n == 0) ? 8'h00 : {7'b0, vf[0]};
        e.draws  = (!clr && n != 0) ? 2 : 0;
        e.clears = clr ? 1 : 0;
        e.sprite = spr;
        e.row    = y % 8'd32;
        e.col    = x % 8'd64;
        e.height = n;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 0, 1);
        exp_q.push_back(e);
        foreach (al[j]) begin
            addr_q.push_back(al[j]);
            wait_q.push_back(wl[j]);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
`ifdef GPU_VBLANK_WAIT_EN
        if (!clr && n != 0) begin
            fork
                begin
                    repeat (vb_delay + 1) @(negedge clk);
                    bus.vblank = 1'b1;
                    @(negedge clk);
                    bus.vblank = 1'b0;
                end
            join_none
        end
`endif
    endtask

    // Busy-time command inputs are scrambled; the controller must ignore them.
    task automatic wait_done();
        int guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            if (bus.done) break;
            guard++;
            bus.cmd_valid = 1'($urandom_range(1));
            bus.cmd_clear = 1'($urandom_range(1));
            bus.cmd_x     = 8'($urandom);
            bus.cmd_y     = 8'($urandom);
            bus.cmd_n     = 4'($urandom);
            bus.cmd_i     = ADDR_W'($urandom);
        end
        bus.cmd_valid = 1'b0;
        if (guard >= 300) check("done_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_mem_req"}, bus.mem_req, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_gpu_draw"}, bus.gpu_draw, 0);
        check({tag, "_gpu_clear"}, bus.gpu_clear, 0);
        check({tag, "_sprite"}, bus.gpu_sprite_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        int guard;
        bit clr;
        logic [3:0] n;
        for (int k = 0; k < MEM_SZ; k++) mem[k] = 8'($urandom);
        bus.cmd_valid = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_n     = '0;
        bus.cmd_i     = '0;
        bus.gpu_vf    = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
`ifdef GPU_VBLANK_WAIT_EN
        bus.vblank    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_done_vf", bus.done_vf, 0);
        check("reset_gpu_row", bus.gpu_row, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a 5-row fetch.
        base = ack_cnt;
        start_cmd(1'b0, 8'd1, 8'd1, 4'd5, 12'h200, 8'h00, 0, 0);
        guard = 0;
        while (ack_cnt < base + 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midfetch_acks", ack_cnt - base, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midfetch_rst");
        exp_q.delete();
        addr_q.delete();
        wait_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        start_cmd(1'b1, 8'd9, 8'd9, 4'd3, 12'h123, 8'hFF, 0, 0);
        wait_done();
        mem[12'h050] = 8'hF0;
        mem[12'h051] = 8'h90;
        start_cmd(1'b0, 8'd2, 8'd3, 4'd2, 12'h050, 8'h00, 0, 2);
        wait_done();
        start_cmd(1'b0, 8'd2, 8'd3, 4'd2, 12'h050, 8'h01, 0, 0);
        wait_done();
        start_cmd(1'b0, 8'd70, 8'd40, 4'd1, 12'hFFF, 8'h00, 3, 4);
        wait_done();
        start_cmd(1'b0, 8'd5, 8'd5, 4'd0, 12'h300, 8'hFF, 0, 0);
        wait_done();
        start_cmd(1'b0, 8'd255, 8'd255, 4'd15, 12'hFF8, 8'hFE, -1, 1);
        wait_done();

        for (int t = 0; t < 60; t++) begin
            clr = ($urandom_range(5) == 0);
            n   = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            start_cmd(clr, 8'($urandom), 8'($urandom), n,
                      ($urandom_range(3) == 0) ? ADDR_W'(12'hFF0 + 12'($urandom_range(15))) : ADDR_W'($urandom),
                      8'($urandom), -1, int'($urandom_range(5)));
            wait_done();
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("leftover_expectations", exp_q.size(), 0);
        check("leftover_reads", addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
